cpu_multicycle: RTL and testbench

Parametrised, multicycle successor to the single-cycle Hack CPU. It has the same instruction semantics (A-/C-instructions, comp/dest/jump fields), but data width is generic. Instruction fetch and data memory are decoupled through valid/ready handshakes, so the core can sit behind wait-stated ROM/RAM, UART or VGA buffers. It adds a halt detector for the canonical `@self; 0;JMP` idle loop.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/alu_param.sv | 28 ++
 rtl/cpu_multicycle.sv | 121 ++++++++++++
 tb/tb_cpu_multicycle.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared Hack instruction field positions, jump codes and FSM states
package cpu_pkg;
  localparam int A_BIT = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int JMP_HI = 2;
  localparam int JMP_LO = 0;
  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT = 3'b001;
  localparam logic [2:0] JEQ = 3'b010;
  localparam logic [2:0] JGE = 3'b011;
  localparam logic [2:0] JLT = 3'b100;
  localparam logic [2:0] JNE = 3'b101;
  localparam logic [2:0] JLE = 3'b110;
  localparam logic [2:0] JMP = 3'b111;
  typedef enum logic [1:0] {FETCH, READ, EXEC, WRITE} state_t;
  // The A/C type flag is the MSB of the word, so its position follows WIDTH
  function automatic int type_bit(input int width);
    return width - 1;
  endfunction
endpackage

// File: rtl/alu_param.sv
// alu_param: WIDTH-generic combinational Hack ALU
module alu_param #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] xa, xb, ya, yb, r;
  always_comb begin
    xa = zx ? '0 : x;
    xb = nx ? ~xa : xa;
    ya = zy ? '0 : y;
    yb = ny ? ~ya : ya;
    r = f ? xb + yb : xb & yb;
    out = no ? ~r : r;
  end
  assign zr = (out == '0);
  assign ng = out[WIDTH-1];
endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: Hack CPU with FETCH/READ/EXEC/WRITE sequencing and
// valid/ready memory handshakes; all architectural state commits on one edge.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PC_W = 15,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [PC_W-1:0]  pc,
  input  logic             imem_valid,
  input  logic [WIDTH-1:0] instruction,
  input  logic [WIDTH-1:0] inM,
  input  logic             mem_ready,
  output logic             readM,
  output logic             writeM,
  output logic [WIDTH-1:0] addressM,
  output logic [WIDTH-1:0] outM,
  output logic             halted
);
  localparam int TB = type_bit(WIDTH);
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, d_q, d_d, out_q, out_d, alu_out;
  logic halted_q, halted_d, rd_q, rd_d, wr_q, wr_d;
  logic zr, ng, cond, jump, commit, is_c;
  assign is_c = ir_q[TB];
  alu_param #(.WIDTH(WIDTH)) u_alu (
    .x(d_q), .y(ir_q[A_BIT] ? mdr_q : a_q),
    .zx(ir_q[COMP_HI]), .nx(ir_q[COMP_HI-1]), .zy(ir_q[COMP_HI-2]),
    .ny(ir_q[COMP_HI-3]), .f(ir_q[COMP_LO+1]), .no(ir_q[COMP_LO]),
    .out(alu_out), .zr(zr), .ng(ng)
  );
  always_comb begin
    case (ir_q[JMP_HI:JMP_LO])
      JGT: cond = !zr && !ng;
      JEQ: cond = zr;
      JGE: cond = !ng;
      JLT: cond = ng;
      JNE: cond = !zr;
      JLE: cond = zr || ng;
      JMP: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end
  assign jump = is_c && cond;
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    mdr_d = mdr_q;
    out_d = out_q;
    a_d = a_q;
    d_d = d_q;
    pc_d = pc_q;
    halted_d = halted_q;
    commit = 1'b0;
    case (state_q)
      FETCH: if (imem_valid) begin
        ir_d = instruction;
        state_d = (instruction[TB] && instruction[A_BIT]) ? READ : EXEC;
      end
      READ: if (mem_ready) begin
        mdr_d = inM;
        state_d = EXEC;
      end
      EXEC: if (is_c && ir_q[DEST_M]) begin
        out_d = alu_out;
        state_d = WRITE;
      end else begin
        commit = 1'b1;
        state_d = FETCH;
      end
      WRITE: if (mem_ready) begin
        commit = 1'b1;
        state_d = FETCH;
      end
    endcase
    // Jump target and halt test use A as it was before this commit
    if (commit) begin
      d_d = (is_c && ir_q[DEST_D]) ? alu_out : d_q;
      a_d = !is_c ? {1'b0, ir_q[TB-1:0]} : ir_q[DEST_A] ? alu_out : a_q;
      pc_d = jump ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
      halted_d = jump && ir_q[JMP_HI:JMP_LO] == JMP && a_q[PC_W-1:0] == pc_q;
    end
    rd_d = (state_d == READ);
    wr_d = (state_d == WRITE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q <= PC_W'(RESET_VECTOR);
      ir_q <= '0;
      mdr_q <= '0;
      a_q <= '0;
      d_q <= '0;
      out_q <= '0;
      halted_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      mdr_q <= mdr_d;
      a_q <= a_d;
      d_q <= d_d;
      out_q <= out_d;
      halted_q <= halted_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
  assign pc = pc_q;
  assign readM = rd_q;
  assign writeM = wr_q;
  assign addressM = a_q;
  assign outM = out_q;
  assign halted = halted_q;
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed programs against a 16-bit core and a 24-bit core
module tb_cpu_multicycle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_valid = 1'b1;
  logic [14:0] pc;
  logic [15:0] instruction, inM, addressM, outM;
  logic mem_ready, readM, writeM, halted;
  logic [15:0] rom [0:63];
  logic [15:0] ram [0:255];
  int wait_n = 0;
  int cnt = 0;
  int n_wr = 0;
  int n_rd = 0;
  logic [15:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic overlap = 1'b0;
  int n_chk = 0;
  int n_err = 0;

  logic [15:0] pc24;
  logic [23:0] ins24, addr24, out24;
  logic rd24, wr24, halted24;
  logic [23:0] rom24 [0:7];

  always #5 clk = ~clk;

  assign instruction = rom[pc[5:0]];
  assign inM = ram[addressM[7:0]];
  assign mem_ready = (readM || writeM) && cnt >= wait_n;
  assign ins24 = rom24[pc24[2:0]];

  cpu_multicycle dut (
    .clk(clk), .reset(rst_n), .pc(pc), .imem_valid(imem_valid),
    .instruction(instruction), .inM(inM), .mem_ready(mem_ready),
    .readM(readM), .writeM(writeM), .addressM(addressM), .outM(outM),
    .halted(halted)
  );

  cpu_multicycle #(.WIDTH(24), .PC_W(16)) dut24 (
    .clk(clk), .reset(rst_n), .pc(pc24), .imem_valid(imem_valid),
    .instruction(ins24), .inM(24'h0), .mem_ready(rd24 || wr24),
    .readM(rd24), .writeM(wr24), .addressM(addr24), .outM(out24),
    .halted(halted24)
  );

  // Wait-stated RAM; reset clears the bookkeeping and seeds RAM[100]
  always @(posedge clk) begin
    if (!rst_n) begin
      cnt <= 0;
      n_wr <= 0;
      n_rd <= 0;
      overlap <= 1'b0;
      ram[100] <= 16'hFFFF;
    end else begin
      if ((readM || writeM) && !mem_ready) cnt <= cnt + 1;
      else cnt <= 0;
      if (writeM && mem_ready) begin
        ram[addressM[7:0]] <= outM;
        n_wr <= n_wr + 1;
        last_addr <= addressM;
        last_data <= outM;
      end
      if (readM && mem_ready) n_rd <= n_rd + 1;
      if (readM && writeM) overlap <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rst_on();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] dset [0:2] = '{16'hEE90, 16'hEA90, 16'hEFD0};
  logic [7:0] masks [0:2] = '{8'b1111_0000, 8'b1100_1100, 8'b1010_1010};

  initial begin
    logic [7:0] m;
    // @5; D=A; @7; M=D with zero wait states
    rom[0] = 16'h0005;
    rom[1] = 16'hEC10;
    rom[2] = 16'h0007;
    rom[3] = 16'hE308;
    wait_n = 0;
    rst_on();
    rst_n = 1'b1;
    ticks(8);
    chk("prog1_pc_at8", pc, 3);
    chk("prog1_wr_at8", n_wr, 0);
    chk("prog1_writeM_at8", writeM, 1);
    ticks(1);
    chk("prog1_pc_at9", pc, 4);
    chk("prog1_nwr", n_wr, 1);
    chk("prog1_addr", last_addr, 7);
    chk("prog1_data", last_data, 5);

    // M=-1 stuck in WRITE, then asynchronous reset
    wait_n = 100;
    rom[4] = 16'hEE88;
    ticks(2);
    chk("midw_writeM", writeM, 1);
    chk("midw_outM", outM, 16'hFFFF);
    chk("midw_addr", addressM, 7);
    rst_n = 1'b0;
    #1;
    chk("rst_writeM", writeM, 0);
    chk("rst_readM", readM, 0);
    chk("rst_pc", pc, 0);
    chk("rst_A", addressM, 0);
    chk("rst_outM", outM, 0);
    chk("rst_halted", halted, 0);
    @(posedge clk);
    #1;
    rom[0] = 16'h0009;
    rom[1] = 16'hE308;
    wait_n = 0;
    rst_n = 1'b1;
    ticks(1);
    chk("post_rst_pc", pc, 0);
    ticks(4);
    chk("post_rst_pc5", pc, 2);
    chk("post_rst_nwr", n_wr, 1);
    chk("post_rst_addr", last_addr, 9);
    chk("post_rst_D0", last_data, 0);

    // @100; M=M+1 with two wait states per access
    rst_on();
    rom[0] = 16'h0064;
    rom[1] = 16'hFDC8;
    wait_n = 2;
    rst_n = 1'b1;
    ticks(9);
    chk("rmw_pc_at9", pc, 1);
    chk("rmw_writeM_at9", writeM, 1);
    chk("rmw_readM_at9", readM, 0);
    chk("rmw_nrd", n_rd, 1);
    ticks(1);
    chk("rmw_pc_at10", pc, 2);
    chk("rmw_nwr", n_wr, 1);
    chk("rmw_addr", last_addr, 100);
    chk("rmw_data", last_data, 16'h0000);
    chk("rmw_overlap", overlap, 0);
    chk("rmw_writeM_drop", writeM, 0);

    // Fetch stall while imem_valid is low
    rom[2] = 16'h0000;
    imem_valid = 1'b0;
    ticks(4);
    chk("stall_pc", pc, 2);
    imem_valid = 1'b1;
    ticks(2);
    chk("stall_resume_pc", pc, 3);

    // Jump sweep: D in {-1,0,1} x jump 001..111, target @42
    wait_n = 0;
    for (int k = 0; k < 3; k++) begin
      m = masks[k];
      for (int j = 1; j < 8; j++) begin
        rst_on();
        rom[0] = dset[k];
        rom[1] = 16'h002A;
        rom[2] = 16'hE300 | 16'(j);
        rst_n = 1'b1;
        ticks(6);
        chk($sformatf("jmp_d%0d_j%0d", k, j), pc, m[j] ? 42 : 3);
      end
    end
    rst_on();
    rom[0] = 16'h002A;
    rom[1] = 16'h0007;
    rst_n = 1'b1;
    ticks(4);
    chk("ainst_nojump_pc", pc, 2);
    chk("ainst_A", addressM, 7);

    // Halt detection on @3; 0;JMP at address 3
    rst_on();
    rom[0] = 16'h0000;
    rom[1] = 16'h0000;
    rom[2] = 16'h0003;
    rom[3] = 16'hEA87;
    rst_n = 1'b1;
    ticks(7);
    chk("halt_before", halted, 0);
    ticks(1);
    chk("halt_set", halted, 1);
    chk("halt_pc", pc, 3);
    ticks(10);
    chk("halt_stays", halted, 1);
    chk("halt_pc_stays", pc, 3);
    rom[3] = 16'hEFD0;
    ticks(2);
    chk("halt_cleared", halted, 0);
    chk("halt_clear_pc", pc, 4);

    // 24-bit core, 16-bit PC
    rst_on();
    rom24[0] = 24'h3FFFFF;
    rom24[1] = 24'hFFEE90;
    rom24[2] = 24'hFFE308;
    rom24[3] = 24'hFFE304;
    rom24[4] = 24'h000000;
    rom24[5] = 24'h000000;
    rom24[6] = 24'h000000;
    rom24[7] = 24'h000005;
    rst_n = 1'b1;
    ticks(2);
    chk("w24_A_imm", addr24, 24'h3FFFFF);
    ticks(5);
    chk("w24_Dneg1", out24, 24'hFFFFFF);
    chk("w24_pc3", pc24, 3);
    ticks(2);
    chk("w24_jlt_ng", pc24, 16'hFFFF);
    ticks(2);
    chk("w24_pc_wrap", pc24, 0);
    chk("w24_A5", addr24, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
